// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared types and constants for the seven-segment display blocks.
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } seg7_state_e;

    localparam int SEG_W  = 8;
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [SEG_W-1:0] SEG_OFF_AL = 8'hFF;

    // Active-low glyphs {dp,g,f,e,d,c,b,a}; entry n lives at bits [8n+7:8n].
    localparam logic [16*SEG_W-1:0] HEX_AL_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [SEG_W-1:0] hex_al(input logic [3:0] nibble);
        return HEX_AL_TABLE[{nibble, 3'b000} +: SEG_W];
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_mux_if
// Purpose : Display-data inputs and scanned pin outputs of the digit scanner.
// Revision: 1.0 - initial release
// ============================================================================
interface seg7_scan_mux_if
    import seg7_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int SEL_W  = $clog2(DIGITS)
);
    logic                  en;
    logic [4*DIGITS-1:0]   data_in;
    logic [DIGITS-1:0]     blank_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_en;
    logic [SEL_W-1:0]      sel;
    logic [DIGITS-1:0]     sel_oh;
    logic [SEG_W-1:0]      seg;
    logic                  frame_done;

    modport master (
        output en, data_in, blank_in, dp_in, lz_en,
        input  sel, sel_oh, seg, frame_done
    );

    modport slave (
        input  en, data_in, blank_in, dp_in, lz_en,
        output sel, sel_oh, seg, frame_done
    );
endinterface : seg7_scan_mux_if
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_hex_decode
// Purpose : Combinational hex-to-segment decode with dp, blank and polarity.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       i_nibble,
    input  logic             i_dp,
    input  logic             i_blank,
    input  logic             i_active_low,
    output logic [SEG_W-1:0] o_seg
);
    logic [SEG_W-1:0] w_al;

    always_comb begin
        w_al         = hex_al(i_nibble);
        w_al[SEG_DP] = ~i_dp;
        if (i_blank) begin
            w_al = SEG_OFF_AL;
        end
        o_seg = i_active_low ? w_al : ~w_al;
    end
endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_mux
// Purpose : Multiplexed hex display scanner with frame shadowing and gaps.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int GAP_CYC        = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_W          = $clog2(DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_mux_if.slave   bus
);
    localparam int                 c_CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_SLOT_END  = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DRIVE_END = c_CNT_W'(SCAN_DIV - GAP_CYC - 1);
    localparam logic               c_GAP_EN    = (GAP_CYC != 0);
    localparam logic [SEL_W-1:0]   c_LAST      = SEL_W'(DIGITS - 1);
    localparam logic               c_ACT_LOW   = (SEG_ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0]   c_SEG_OFF   = c_ACT_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;

    localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [1:0] c_ST_DRIVE = ST_DRIVE;
    localparam logic [1:0] c_ST_GAP   = ST_GAP;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]    r_d;
    logic [4*DIGITS-1:0] r_sh_data;
    logic [DIGITS-1:0]   r_sh_blank;
    logic [DIGITS-1:0]   r_sh_dp;
    logic                r_sh_lz;
    logic [SEL_W-1:0]    r_sel;
    logic [DIGITS-1:0]   r_sel_oh;
    logic [SEG_W-1:0]    r_seg;
    logic                r_frame_done;

    logic [1:0]          w_state_nx;
    logic [c_CNT_W-1:0]  w_cnt_nx;
    logic [SEL_W-1:0]    w_d_nx;
    logic                w_slot_end;
    logic                w_load;
    logic                w_wrap;
    logic [4*DIGITS-1:0] w_sh_data_nx;
    logic [DIGITS-1:0]   w_sh_blank_nx;
    logic [DIGITS-1:0]   w_sh_dp_nx;
    logic                w_sh_lz_nx;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_dark;
    logic                w_allz;
    logic [SEG_W-1:0]    w_dec;

    // Next state; en low always wins, so an aborted frame never wraps.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_d_nx     = r_d;
        w_slot_end = 1'b0;
        w_load     = 1'b0;
        w_wrap     = 1'b0;
        if (!bus.en) begin
            w_state_nx = c_ST_IDLE;
            w_cnt_nx   = '0;
            w_d_nx     = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nx = c_ST_DRIVE;
                    w_cnt_nx   = '0;
                    w_d_nx     = '0;
                    w_load     = 1'b1;
                end
                c_ST_DRIVE: begin
                    if (c_GAP_EN && (r_cnt == c_DRIVE_END)) begin
                        w_state_nx = c_ST_GAP;
                        w_cnt_nx   = r_cnt + 1'b1;
                    end else if (!c_GAP_EN && (r_cnt == c_SLOT_END)) begin
                        w_slot_end = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (r_cnt == c_SLOT_END) begin
                        w_slot_end = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = c_ST_IDLE;
                    w_cnt_nx   = '0;
                    w_d_nx     = '0;
                end
            endcase
            if (w_slot_end) begin
                w_state_nx = c_ST_DRIVE;
                w_cnt_nx   = '0;
                if (r_d == c_LAST) begin
                    w_d_nx = '0;
                    w_wrap = 1'b1;
                    w_load = 1'b1;
                end else begin
                    w_d_nx = r_d + 1'b1;
                end
            end
        end
    end

    assign w_sh_data_nx  = w_load ? bus.data_in  : r_sh_data;
    assign w_sh_blank_nx = w_load ? bus.blank_in : r_sh_blank;
    assign w_sh_dp_nx    = w_load ? bus.dp_in    : r_sh_dp;
    assign w_sh_lz_nx    = w_load ? bus.lz_en    : r_sh_lz;

    // Digit 0 is the most significant nibble; w_allz tracks "digits 0..i all zero".
    always_comb begin
        w_nib  = 4'h0;
        w_dp   = 1'b0;
        w_dark = 1'b1;
        w_allz = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_allz = w_allz && (w_sh_data_nx[4*(DIGITS-1-i) +: 4] == 4'h0);
            if (w_d_nx == SEL_W'(i)) begin
                w_nib  = w_sh_data_nx[4*(DIGITS-1-i) +: 4];
                w_dp   = w_sh_dp_nx[i];
                w_dark = w_sh_blank_nx[i] || (w_sh_lz_nx && w_allz && (i != DIGITS - 1));
            end
        end
    end

    seg7_hex_decode u_dec (
        .i_nibble     (w_nib),
        .i_dp         (w_dp),
        .i_blank      (w_dark),
        .i_active_low (c_ACT_LOW),
        .o_seg        (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_d          <= '0;
            r_sh_data    <= '0;
            r_sh_blank   <= '0;
            r_sh_dp      <= '0;
            r_sh_lz      <= 1'b0;
            r_sel        <= '0;
            r_sel_oh     <= '0;
            r_seg        <= c_SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_d          <= w_d_nx;
            r_sh_data    <= w_sh_data_nx;
            r_sh_blank   <= w_sh_blank_nx;
            r_sh_dp      <= w_sh_dp_nx;
            r_sh_lz      <= w_sh_lz_nx;
            r_sel        <= (w_state_nx == c_ST_IDLE) ? '0 : w_d_nx;
            r_sel_oh     <= (w_state_nx == c_ST_DRIVE) ? (DIGITS'(1) << w_d_nx) : '0;
            r_seg        <= (w_state_nx == c_ST_DRIVE) ? w_dec : c_SEG_OFF;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.sel        = r_sel;
    assign bus.sel_oh     = r_sel_oh;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_frame_done;

endmodule : seg7_scan_mux
`default_nettype wire
